// File: rtl/ifu_rom_rsp_pkg.sv
// Shared encodings for the instruction-fetch ROM responder: AXI response codes
// (same values the decode stage uses) and the responder FSM states.
package ifu_rom_rsp_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Galois feedback mask for x^8+x^6+x^5+x^4+1 (right-shifting form)
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Out-of-range wins over misalignment.
    function automatic logic [1:0] resp_decode(input logic in_range, input logic misaligned);
        if (!in_range) begin
            return RESP_DECERR;
        end
        if (misaligned) begin
            return RESP_SLVERR;
        end
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/ifu_rom_rsp_lfsr8.sv
// 8-bit Galois LFSR used as the random extra-delay source; steps only when en is high.
module lfsr8
    import ifu_rom_rsp_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    output logic [7:0] q
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 8'h00);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q <= 8'h01;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/ifu_rom_rsp.sv
// AXI4-Lite R-channel responder over a word-addressed instruction SRAM with a
// loader write port; one outstanding fetch, fixed plus optional random latency.
//   state | meaning
//   IDLE  | arready high, waiting for an AR handshake
//   WAIT  | response captured, latency counter running down
//   RESP  | rvalid high, holding rdata/rresp until rready
module ifu_rom_rsp
    import ifu_rom_rsp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 1,
    parameter bit          RAND_EN     = 1'b0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [31:0]                    araddr_i,
    input  logic                           arvalid_i,
    output logic                           arready_o,
    output logic [31:0]                    rdata_o,
    output logic                           rvalid_o,
    output logic [1:0]                     rresp_o,
    input  logic                           rready_i,
    input  logic                           load_en_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_idx_i,
    input  logic [31:0]                    load_data_i
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam int          CNT_W    = $clog2(LATENCY + 5);
    localparam logic [32:0] BASE_33  = {1'b0, BASE_ADDR};
    localparam logic [32:0] LIMIT_33 = BASE_33 + 33'(DEPTH_WORDS) * 33'd4;

    logic [31:0] mem_q [DEPTH_WORDS];

    state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;

    logic             ar_hs;
    logic [7:0]       lfsr_q;
    logic [1:0]       extra_delay;
    logic [CNT_W-1:0] ld_delay;
    logic             in_range;
    logic [IDX_W-1:0] word_idx;

    // Loader writes land after the same-edge fetch capture, so a colliding fetch sees the old word.
    always_ff @(posedge clock) begin
        if (load_en_i) begin
            mem_q[load_idx_i] <= load_data_i;
        end
    end

    assign ar_hs = arvalid_i && arready_q;

    generate
        if (RAND_EN) begin : g_rand
            lfsr8 u_lfsr8 (
                .clock (clock),
                .reset (reset),
                .en    (ar_hs),
                .q     (lfsr_q)
            );
        end else begin : g_fixed
            assign lfsr_q = 8'h00;
        end
    endgenerate

    assign extra_delay = 2'(lfsr_q);
    assign ld_delay    = CNT_W'(LATENCY) + CNT_W'(extra_delay);

    // 33-bit compare keeps a window ending at 2^32 from wrapping onto low addresses.
    assign in_range = ({1'b0, araddr_i} >= BASE_33) && ({1'b0, araddr_i} < LIMIT_33);
    assign word_idx = IDX_W'((araddr_i - BASE_ADDR) >> 2);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        case (state_q)
            ST_IDLE: begin
                if (ar_hs) begin
                    rresp_d = resp_decode(in_range, araddr_i[1:0] != 2'b00);
                    rdata_d = (rresp_d == RESP_OKAY) ? mem_q[word_idx] : 32'h0;
                    cnt_d   = ld_delay;
                    state_d = (ld_delay != '0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rvalid_q && rready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        arready_d = (state_d == ST_IDLE);
        rvalid_d  = (state_d == ST_RESP);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rdata_q   <= 32'h0;
            rresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign arready_o = arready_q;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;

endmodule
